// File: rtl/ascii_pkg.sv
// Shared types and constants for the ASCII-art glyph scheduler.
//   sched_state_e : scheduler FSM states
//   GLYPH_W/ROW_W/N_ROWS/IDX_W : glyph ROM geometry
//   luma2idx()    : maps the top luminance nibble to a glyph index
package ascii_pkg;

  localparam int unsigned GLYPH_W = 256;
  localparam int unsigned ROW_W   = 16;
  localparam int unsigned N_ROWS  = 16;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRdIssue,
    StRdCapt,
    StEmit
  } sched_state_e;

  // invert=1 maps dark tiles onto dense glyphs.
  function automatic logic [IDX_W-1:0] luma2idx(input logic [IDX_W-1:0] luma_msn,
                                                input logic             invert);
    return invert ? ~luma_msn : luma_msn;
  endfunction

endpackage

// File: rtl/glyph_row_sel.sv
// Combinational 256-to-16 row mux over a glyph bitmap.
//   glyph_i    : 256-bit glyph, row 0 in the top 16 bits
//   row_idx_i  : row number 0..15, top first
//   row_data_o : selected 16-pixel row, bit15 = leftmost pixel
module glyph_row_sel
  import ascii_pkg::*;
(
  input  logic [GLYPH_W-1:0] glyph_i,
  input  logic [IDX_W-1:0]   row_idx_i,
  output logic [ROW_W-1:0]   row_data_o
);

  always_comb begin
    row_data_o = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (row_idx_i == IDX_W'(r)) begin
        row_data_o = glyph_i[GLYPH_W-1-ROW_W*r -: ROW_W];
      end
    end
  end

endmodule

// File: rtl/ascii_glyph_sched.sv
// Glyph ROM controller/arbiter: maps one luminance sample per tile to a glyph,
// reads it from the 1-cycle-latency ROM and streams it as 16 rows over a
// valid/ready handshake. CPU glyph writes share the ROM port and win in idle.
//   clk, rst_n                 : clock, synchronous active-low reset
//   luma_valid/luma/luma_ready : tile luminance input handshake
//   cpu_wr_req/addr/data/ack   : CPU glyph write request, ack is a 1-cycle pulse
//   rom_addr/rom_w_en/rom_wdata: registered ROM controls
//   rom_data                   : ROM read data, valid 1 cycle after address sampled
//   row_valid/row_ready/row_data/row_idx/row_last : glyph row output stream
module ascii_glyph_sched
  import ascii_pkg::*;
#(
  parameter int unsigned LUMA_W = 8,
  parameter int unsigned INVERT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              luma_valid,
  input  logic [LUMA_W-1:0] luma,
  output logic              luma_ready,
  input  logic              cpu_wr_req,
  input  logic [3:0]        cpu_wr_addr,
  input  logic [255:0]      cpu_wr_data,
  output logic              cpu_wr_ack,
  output logic [3:0]        rom_addr,
  output logic              rom_w_en,
  output logic [255:0]      rom_wdata,
  input  logic [255:0]      rom_data,
  output logic              row_valid,
  input  logic              row_ready,
  output logic [15:0]       row_data,
  output logic [3:0]        row_idx,
  output logic              row_last
);

  sched_state_e       state_q, state_d;
  logic [IDX_W-1:0]   rom_addr_q, rom_addr_d;
  logic               rom_w_en_q, rom_w_en_d;
  logic [GLYPH_W-1:0] rom_wdata_q, rom_wdata_d;
  logic               ack_q, ack_d;
  logic               row_valid_q, row_valid_d;
  logic [IDX_W-1:0]   row_idx_q, row_idx_d;
  logic [GLYPH_W-1:0] glyph_q, glyph_d;

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    rom_w_en_d  = 1'b0;
    rom_wdata_d = rom_wdata_q;
    ack_d       = 1'b0;
    row_valid_d = row_valid_q;
    row_idx_d   = row_idx_q;
    glyph_d     = glyph_q;

    unique case (state_q)
      StIdle: begin
        // CPU writes take priority; a concurrent luma sample is left pending.
        if (cpu_wr_req) begin
          rom_addr_d  = cpu_wr_addr;
          rom_wdata_d = cpu_wr_data;
          rom_w_en_d  = 1'b1;
          ack_d       = 1'b1;
          state_d     = StWrite;
        end else if (luma_valid) begin
          rom_addr_d = luma2idx(luma[LUMA_W-1 -: IDX_W], INVERT != 0);
          state_d    = StRdIssue;
        end
      end
      StWrite: begin
        state_d = StIdle;
      end
      StRdIssue: begin
        // ROM samples rom_addr on this edge.
        state_d = StRdCapt;
      end
      StRdCapt: begin
        glyph_d     = rom_data;
        row_idx_d   = '0;
        row_valid_d = 1'b1;
        state_d     = StEmit;
      end
      StEmit: begin
        if (row_valid_q && row_ready) begin
          if (row_idx_q == IDX_W'(N_ROWS - 1)) begin
            row_valid_d = 1'b0;
            state_d     = StIdle;
          end else begin
            row_idx_d = row_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rom_addr_q  <= '0;
      rom_w_en_q  <= 1'b0;
      rom_wdata_q <= '0;
      ack_q       <= 1'b0;
      row_valid_q <= 1'b0;
      row_idx_q   <= '0;
      glyph_q     <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      rom_w_en_q  <= rom_w_en_d;
      rom_wdata_q <= rom_wdata_d;
      ack_q       <= ack_d;
      row_valid_q <= row_valid_d;
      row_idx_q   <= row_idx_d;
      glyph_q     <= glyph_d;
    end
  end

  glyph_row_sel u_row_sel (
    .glyph_i    (glyph_q),
    .row_idx_i  (row_idx_q),
    .row_data_o (row_data)
  );

  assign luma_ready = (state_q == StIdle) && !cpu_wr_req;
  assign rom_addr   = rom_addr_q;
  assign rom_w_en   = rom_w_en_q;
  assign rom_wdata  = rom_wdata_q;
  assign cpu_wr_ack = ack_q;
  assign row_valid  = row_valid_q;
  assign row_idx    = row_idx_q;
  assign row_last   = row_valid_q && (row_idx_q == IDX_W'(N_ROWS - 1));

endmodule

// File: tb/tb_ascii_glyph_sched.sv
// Self-checking bench for ascii_glyph_sched with a behavioural glyph ROM and a
// row scoreboard filled whenever a luma sample is accepted.
module tb_ascii_glyph_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         luma_valid;
  logic [7:0]   luma;
  logic         luma_ready;
  logic         cpu_wr_req;
  logic [3:0]   cpu_wr_addr;
  logic [255:0] cpu_wr_data;
  logic         cpu_wr_ack;
  logic [3:0]   rom_addr;
  logic         rom_w_en;
  logic [255:0] rom_wdata;
  logic [255:0] rom_data;
  logic         row_valid;
  logic         row_ready;
  logic [15:0]  row_data;
  logic [3:0]   row_idx;
  logic         row_last;

  // Inverting instance shares all inputs; only its address is checked.
  logic         inv_luma_ready, inv_cpu_wr_ack, inv_rom_w_en;
  logic         inv_row_valid, inv_row_last;
  logic [3:0]   inv_rom_addr, inv_row_idx;
  logic [255:0] inv_rom_wdata;
  logic [15:0]  inv_row_data;

  always #5 clk = ~clk;

  ascii_glyph_sched #(.LUMA_W(8), .INVERT(0)) dut (
    .clk(clk), .rst_n(rst_n), .luma_valid(luma_valid), .luma(luma),
    .luma_ready(luma_ready), .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr),
    .cpu_wr_data(cpu_wr_data), .cpu_wr_ack(cpu_wr_ack), .rom_addr(rom_addr),
    .rom_w_en(rom_w_en), .rom_wdata(rom_wdata), .rom_data(rom_data),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_idx(row_idx), .row_last(row_last)
  );

  ascii_glyph_sched #(.LUMA_W(8), .INVERT(1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .luma_valid(luma_valid), .luma(luma),
    .luma_ready(inv_luma_ready), .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr),
    .cpu_wr_data(cpu_wr_data), .cpu_wr_ack(inv_cpu_wr_ack), .rom_addr(inv_rom_addr),
    .rom_w_en(inv_rom_w_en), .rom_wdata(inv_rom_wdata), .rom_data(rom_data),
    .row_valid(inv_row_valid), .row_ready(row_ready), .row_data(inv_row_data),
    .row_idx(inv_row_idx), .row_last(inv_row_last)
  );

  function automatic logic [15:0] glyph6_row(input logic [3:0] r);
    case (r)
      4'd2:    return 16'h0180;
      4'd3:    return 16'h0380;
      4'd4:    return 16'h0780;
      4'd5:    return 16'h0D80;
      4'd6:    return 16'h0980;
      4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12: return 16'h0180;
      4'd13:   return 16'h07E0;
      default: return 16'h0000;
    endcase
  endfunction

  // Power-on ROM contents: glyph 0 blank, glyph 6 fixed art, others a pattern.
  function automatic logic [255:0] init_glyph(input logic [3:0] g);
    logic [255:0] v;
    logic [15:0]  row;
    logic [3:0]   rr;
    v = '0;
    for (int r = 0; r < 16; r++) begin
      rr = 4'(r);
      if (g == 4'd0)      row = 16'h0000;
      else if (g == 4'd6) row = glyph6_row(rr);
      else                row = {g, rr, ~g, ~rr};
      v[255-16*r -: 16] = row;
    end
    return v;
  endfunction

  // Behavioural ROM: registered read, read-before-write.
  logic [255:0] rom_over [16];
  logic [15:0]  rom_written = '0;
  always @(posedge clk) begin
    rom_data <= rom_written[rom_addr] ? rom_over[rom_addr] : init_glyph(rom_addr);
    if (rom_w_en) begin
      rom_over[rom_addr]    <= rom_wdata;
      rom_written[rom_addr] <= 1'b1;
    end
  end

  // Expected glyph contents, updated from the writes the bench requests.
  logic [255:0] exp_over [16];
  logic [15:0]  exp_written = '0;

  function automatic logic [255:0] exp_glyph(input logic [3:0] g);
    return exp_written[g] ? exp_over[g] : init_glyph(g);
  endfunction

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  idx;
    logic        last;
  } row_exp_t;

  row_exp_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;
  int hs     = 0;
  int vcyc   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Scoreboard: push on accept, pop on every row handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (luma_valid && luma_ready) begin
        for (int r = 0; r < 16; r++) begin
          row_exp_t e;
          logic [255:0] gl;
          gl     = exp_glyph(luma[7:4]);
          e.data = gl[255-16*r -: 16];
          e.idx  = 4'(r);
          e.last = (r == 15);
          sb.push_back(e);
        end
      end
      if (row_valid) vcyc++;
      if (row_valid && row_ready) begin
        hs++;
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          row_exp_t e;
          e = sb.pop_front();
          chk("row_data", row_data, e.data);
          chk("row_idx", row_idx, e.idx);
          chk("row_last", row_last, e.last);
        end
      end
    end
  end

  task automatic send_luma(input logic [7:0] v);
    bit acc;
    acc        = 1'b0;
    luma       = v;
    luma_valid = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = luma_ready;
      @(posedge clk);
      #1;
    end
    luma_valid = 1'b0;
    chk("luma_accept", acc, 1);
  endtask

  task automatic wait_tile();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !row_valid;
    end
    chk("tile_done", done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_row(input logic [3:0] r);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #1;
      found = row_valid && (row_idx == r);
    end
    chk("row_reached", found, 1);
  endtask

  initial begin
    int hs0, v0, lat;
    logic [255:0] pat5;
    rst_n       = 1'b0;
    luma_valid  = 1'b0;
    luma        = '0;
    cpu_wr_req  = 1'b0;
    cpu_wr_addr = '0;
    cpu_wr_data = '0;
    row_ready   = 1'b1;
    pat5        = {8{32'hA5C3_0F96}};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_rom_w_en", rom_w_en, 0);
    chk("rst_rom_wdata", rom_wdata, 0);
    chk("rst_ack", cpu_wr_ack, 0);
    chk("rst_row_valid", row_valid, 0);
    chk("rst_row_idx", row_idx, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_luma_ready", luma_ready, 1);

    // Glyph 6 tile, full-rate stream with latency check.
    hs0 = hs;
    v0  = vcyc;
    send_luma(8'h6A);
    chk("addr_6a", rom_addr, 6);
    chk("inv_addr_6a", inv_rom_addr, 9);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (row_valid) break;
    end
    chk("first_row_latency", lat, 3);
    wait_tile();
    chk("tile6_handshakes", hs - hs0, 16);
    chk("tile6_valid_cycles", vcyc - v0, 16);

    // Luma 0: blank glyph, inverted instance selects slot 15.
    send_luma(8'h00);
    chk("addr_00", rom_addr, 0);
    chk("inv_addr_00", inv_rom_addr, 15);
    wait_tile();

    // Backpressure at row 4 for 5 cycles.
    hs0 = hs;
    send_luma(8'h25);
    wait_row(4'd4);
    row_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [255:0] g2;
      g2 = init_glyph(4'd2);
      @(negedge clk);
      chk("stall_valid", row_valid, 1);
      chk("stall_idx", row_idx, 4);
      chk("stall_data", row_data, g2[255-64 -: 16]);
    end
    @(posedge clk);
    #1;
    row_ready = 1'b1;
    wait_tile();
    chk("bp_handshakes", hs - hs0, 16);

    // Simultaneous write and luma: write wins, luma follows.
    cpu_wr_req       = 1'b1;
    cpu_wr_addr      = 4'd3;
    cpu_wr_data      = '1;
    exp_over[3]      = '1;
    exp_written[3]   = 1'b1;
    luma_valid       = 1'b1;
    luma             = 8'h35;
    @(negedge clk);
    chk("wr_luma_ready", luma_ready, 0);
    @(posedge clk);
    #1;
    cpu_wr_req = 1'b0;
    chk("wr_w_en", rom_w_en, 1);
    chk("wr_addr", rom_addr, 3);
    chk("wr_wdata", rom_wdata, {256{1'b1}});
    chk("wr_ack", cpu_wr_ack, 1);
    @(negedge clk);
    chk("write_state_ready", luma_ready, 0);
    @(posedge clk);
    #1;
    chk("wr_w_en_pulse", rom_w_en, 0);
    chk("wr_ack_pulse", cpu_wr_ack, 0);
    send_luma(8'h35);
    chk("addr_35", rom_addr, 3);
    wait_tile();

    // CPU request during row 7 waits for the tile to finish.
    hs0 = hs;
    send_luma(8'h10);
    wait_row(4'd7);
    cpu_wr_req     = 1'b1;
    cpu_wr_addr    = 4'd5;
    cpu_wr_data    = pat5;
    exp_over[5]    = pat5;
    exp_written[5] = 1'b1;
    begin
      bit acked;
      acked = 1'b0;
      for (int i = 0; i < 100 && !acked; i++) begin
        @(negedge clk);
        acked = cpu_wr_ack;
      end
      chk("late_ack_seen", acked, 1);
      chk("late_ack_after_tile", hs - hs0, 16);
      chk("late_ack_row_valid", row_valid, 0);
      chk("late_wr_addr", rom_addr, 5);
      chk("late_wr_w_en", rom_w_en, 1);
    end
    @(posedge clk);
    #1;
    cpu_wr_req = 1'b0;
    wait_tile();
    send_luma(8'h5C);
    wait_tile();

    // Reset at row 9 discards the tile; a fresh tile follows.
    send_luma(8'h6A);
    wait_row(4'd9);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    chk("rst_mid_row_valid", row_valid, 0);
    chk("rst_mid_idle", luma_ready, 1);
    @(negedge clk);
    chk("rst_mid_no_rows", row_valid, 0);
    @(posedge clk);
    #1;
    hs0 = hs;
    send_luma(8'h10);
    chk("addr_10", rom_addr, 1);
    wait_tile();
    chk("fresh_tile_handshakes", hs - hs0, 16);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
